muldiv_sequencer: RTL
=====================

MULDIV_SEQUENCER -- requirements
Module: muldiv_sequencer

Interface
REQ-001 Parameter: XLEN, 32, operand/result width.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset; asynchronous, active-low.
REQ-004 start  input  1  request a new M-extension operation (opcode 0110011, funct7 0000001) from EX stage.
REQ-005 funct3  input  3  operation: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-006 opA  input  XLEN  rs1 operand (dividend / multiplicand).
REQ-007 opB  input  XLEN  rs2 operand (divisor / multiplier).
REQ-008 flush  input  1  pipeline flush; aborts any operation in progress.
REQ-009 busy  output  1  high whenever state is not IDLE.
REQ-010 stallReq  output  1  to hazard unit; freezes IF/ID/EX while the operation is computing.
REQ-011 done  output  1  single-cycle pulse; result valid in the same cycle.
REQ-012 result  output  XLEN  operation result; holds its last value until the next done.

Function
REQ-013 States SHALL be IDLE, MUL, DIV, DONE.
REQ-014 IDLE: start=1 with flush=0 SHALL latch funct3, opA and opB at the edge.
  - Multiply funct3 (0xx) SHALL go to MUL.
  - Divide funct3 (1xx) SHALL go to DIV, or to DONE directly on a fast-path case (REQ-018, REQ-019).
REQ-015 stallReq SHALL equal (state==IDLE & start & ~flush) | state==MUL | state==DIV; it SHALL be low in DONE so the pipeline advances with the result.
REQ-016 MUL SHALL be radix-2 shift-add over unsigned magnitudes.
  - It SHALL run exactly XLEN iterations, counted by a 6-bit counter from 0 to XLEN-1, then go to DONE.
  - done SHALL occur XLEN+1 cycles after the start edge.
REQ-017 DIV SHALL be restoring division over unsigned magnitudes.
  - It SHALL run exactly XLEN iterations, then go to DONE.
  - Latency SHALL be the same as MUL.
REQ-018 Divisor 0 SHALL produce: quotient all-ones; remainder = opA. The block SHALL go to DONE directly, giving done 1 cycle after the start edge.
REQ-019 Signed overflow (DIV/REM with opA=0x80000000, opB=0xFFFFFFFF) SHALL produce: quotient 0x80000000; remainder 0. This case SHALL use the same fast path as REQ-018.
REQ-020 Operand signedness:
  - MULH, DIV and REM SHALL treat both operands as signed.
  - MULHSU SHALL treat opA as signed and opB as unsigned.
  - All other operations SHALL be unsigned.
  - Sign correction SHALL be two's-complement negation of the magnitude result.
  - Quotient sign SHALL be signA^signB; remainder sign SHALL be signA.
REQ-021 Result selection: MUL SHALL return product[XLEN-1:0]; MULH, MULHSU and MULHU SHALL return product[2*XLEN-1:XLEN].
REQ-022 DONE SHALL assert done for exactly one cycle, drive result, and return to IDLE at the next edge. A start present during DONE SHALL be ignored.
REQ-023 start while busy SHALL be ignored, with no effect on the latched operands.
REQ-024 flush in any state SHALL force IDLE at the next edge. No done SHALL follow, and result SHALL be unchanged. flush together with start in IDLE SHALL not accept the start.
REQ-025 A new start SHALL be accepted in the first IDLE cycle after DONE or after a flush.

Reset
REQ-026 While rst_n=0 the block SHALL hold:
  - state IDLE; busy 0; stallReq 0; done 0;
  - result 0; iteration counter 0;
  - all internal operand and accumulator registers 0.
REQ-027 Reset asserted mid-operation SHALL abort immediately, asynchronously, with no done pulse after release.

Structure
REQ-028 The shared package SHALL hold the funct3 M-extension encodings, the state enum, and XLEN.
REQ-029 Sign correction (magnitude in, signed result out) SHALL be a combinational sub-module muldiv_sign_fix; everything else SHALL stay in muldiv_sequencer.

Verification
REQ-030 MUL opA=7, opB=0xFFFFFFFD -> result 0xFFFFFFEB, done exactly 33 cycles after start edge, stallReq high for cycles 0..32.
REQ-031 MULHU opA=opB=0xFFFFFFFF -> result 0xFFFFFFFE; MULH same operands -> 0x00000000.
REQ-032 DIVU 100/7 -> 14 and REMU 100/7 -> 2; DIV 0xFFFFFF9C(-100)/7 -> 0xFFFFFFF2; REM -> 0xFFFFFFFE.
REQ-033 DIV 5/0 -> 0xFFFFFFFF and REM 5/0 -> 5, each with done 1 cycle after the start edge; DIV 0x80000000/0xFFFFFFFF -> 0x80000000 with the same fast-path latency.
REQ-034 flush at cycle 10 of a DIV -> IDLE next cycle, no done, result unchanged; a back-to-back start is then accepted and gives correct results.
REQ-035 rst_n pulsed low mid-MUL -> all outputs 0 immediately, no done after release; start held during busy -> ignored.

Source files
------------

// File: rtl/muldiv_sequencer_pkg.sv
// muldiv_sequencer_pkg: shared width, M-extension funct3 encodings and FSM states.
package muldiv_sequencer_pkg;
    localparam int XLEN = 32;

    typedef enum logic [2:0] {
        F3_MUL    = 3'b000,
        F3_MULH   = 3'b001,
        F3_MULHSU = 3'b010,
        F3_MULHU  = 3'b011,
        F3_DIV    = 3'b100,
        F3_DIVU   = 3'b101,
        F3_REM    = 3'b110,
        F3_REMU   = 3'b111
    } funct3_e;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_e;
endpackage

// File: rtl/muldiv_sequencer_if.sv
// muldiv_sequencer_if: EX-stage request and result/stall signals of the multiply/divide unit.
interface muldiv_sequencer_if;
    import muldiv_sequencer_pkg::*;
    logic            start;
    logic [2:0]      funct3;
    logic [XLEN-1:0] opA;
    logic [XLEN-1:0] opB;
    logic            flush;
    logic            busy;
    logic            stallReq;
    logic            done;
    logic [XLEN-1:0] result;

    modport master (output start, funct3, opA, opB, flush, input busy, stallReq, done, result);
    modport slave  (input start, funct3, opA, opB, flush, output busy, stallReq, done, result);
endinterface

// File: rtl/muldiv_sign_fix.sv
// muldiv_sign_fix: applies operand signs to an unsigned product or {remainder, quotient} and selects the result.
module muldiv_sign_fix
    import muldiv_sequencer_pkg::*;
(
    input  logic [2:0]        funct3_i,
    input  logic              neg_a_i,
    input  logic              neg_b_i,
    input  logic [2*XLEN-1:0] mag_i,
    output logic [XLEN-1:0]   result_o
);
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quo;
    logic [XLEN-1:0]   rem;

    always_comb begin
        prod     = (neg_a_i ^ neg_b_i) ? -mag_i : mag_i;
        quo      = (neg_a_i ^ neg_b_i) ? -mag_i[XLEN-1:0] : mag_i[XLEN-1:0];
        rem      = neg_a_i ? -mag_i[2*XLEN-1:XLEN] : mag_i[2*XLEN-1:XLEN];
        result_o = funct3_i[2] ? (funct3_i[1] ? rem : quo)
                 : (funct3_i == F3_MUL ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN]);
    end
endmodule

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: iterative RV32M multiply (shift-add) and divide (restoring), one bit per cycle.
module muldiv_sequencer
    import muldiv_sequencer_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    muldiv_sequencer_if.slave  bus
);
    state_e            state_q;
    logic [2:0]        funct3_q;
    logic              neg_a_q, neg_b_q, done_q;
    logic [5:0]        cnt_q;
    logic [XLEN-1:0]   m_q, result_q;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic              neg_a, neg_b, div0, ovf, is_rem, accept;
    logic [XLEN-1:0]   mag_a, mag_b, fast_res, fixed;
    logic [XLEN:0]     add_sum, rem_sh, diff;

    always_comb begin
        neg_a    = (bus.funct3 inside {F3_MULH, F3_MULHSU, F3_DIV, F3_REM}) & bus.opA[XLEN-1];
        neg_b    = (bus.funct3 inside {F3_MULH, F3_DIV, F3_REM}) & bus.opB[XLEN-1];
        mag_a    = neg_a ? -bus.opA : bus.opA;
        mag_b    = neg_b ? -bus.opB : bus.opB;
        is_rem   = bus.funct3[1];
        div0     = bus.funct3[2] && bus.opB == '0;
        ovf      = (bus.funct3 == F3_DIV || bus.funct3 == F3_REM)
                   && bus.opA == {1'b1, {(XLEN-1){1'b0}}} && bus.opB == '1;
        fast_res = div0 ? (is_rem ? bus.opA : '1) : (is_rem ? '0 : bus.opA);
        accept   = rst_n && state_q == S_IDLE && bus.start && !bus.flush;
        // acc_q holds {partial product, multiplier} for MUL and {remainder, quotient} for DIV
        add_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, m_q} : '0);
        rem_sh   = acc_q[2*XLEN-1:XLEN-1];
        diff     = rem_sh - {1'b0, m_q};
        acc_d    = state_q == S_MUL ? {add_sum, acc_q[XLEN-1:1]}
                 : {diff[XLEN] ? rem_sh[XLEN-1:0] : diff[XLEN-1:0], acc_q[XLEN-2:0], ~diff[XLEN]};
    end

    muldiv_sign_fix u_sign_fix (
        .funct3_i (funct3_q),
        .neg_a_i  (neg_a_q),
        .neg_b_i  (neg_b_q),
        .mag_i    (acc_d),
        .result_o (fixed)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            funct3_q <= '0;
            neg_a_q  <= 1'b0;
            neg_b_q  <= 1'b0;
            done_q   <= 1'b0;
            cnt_q    <= '0;
            m_q      <= '0;
            acc_q    <= '0;
            result_q <= '0;
        end else if (bus.flush) begin
            state_q <= S_IDLE;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: if (bus.start) begin
                    funct3_q <= bus.funct3;
                    neg_a_q  <= neg_a;
                    neg_b_q  <= neg_b;
                    cnt_q    <= '0;
                    if (!bus.funct3[2]) begin
                        state_q <= S_MUL;
                        m_q     <= mag_a;
                        acc_q   <= {{XLEN{1'b0}}, mag_b};
                    end else if (div0 || ovf) begin
                        state_q  <= S_DONE;
                        done_q   <= 1'b1;
                        result_q <= fast_res;
                    end else begin
                        state_q <= S_DIV;
                        m_q     <= mag_b;
                        acc_q   <= {{XLEN{1'b0}}, mag_a};
                    end
                end
                S_MUL, S_DIV: begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_q + 6'd1;
                    if (cnt_q == 6'(XLEN-1)) begin
                        state_q  <= S_DONE;
                        done_q   <= 1'b1;
                        result_q <= fixed;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy     = state_q != S_IDLE;
    assign bus.stallReq = accept || state_q == S_MUL || state_q == S_DIV;
    assign bus.done     = done_q;
    assign bus.result   = result_q;
endmodule
